param_sequence_generator: RTL and testbench

//   Parametrised, table-driven pattern generator: steps through a DEPTH-entry, WIDTH-bit

---
 rtl/seqgen_pkg.sv | 20 ++
 rtl/seq_tick_divider.sv | 36 +++
 rtl/param_sequence_generator.sv | 164 ++++++++++++++++
 tb/tb_param_sequence_generator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seqgen_pkg.sv
// Shared types for the table-driven sequence generator.
package seqgen_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_LOOP     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_tick_divider.sv
// Step-period divider: counts enabled cycles and emits a 1-cycle tick when the
// count reaches ratio_i, so one tick occurs every ratio_i+1 enabled cycles.
module seq_tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] ratio_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == ratio_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_sequence_generator.sv
// Table-driven pattern generator with one-shot, loop and ping-pong playback.
// Ping-pong (mode 10) exists only when SEQGEN_PINGPONG_EN is defined; otherwise it plays as loop.
module param_sequence_generator
  import seqgen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [AW-1:0]    last_idx,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data_out,
  output logic [AW-1:0]    index,
  output logic             step,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  mode_e            mode_q;
  logic [DIV_W-1:0] div_q;
  logic [AW-1:0]    last_q;
  logic [AW-1:0]    index_q;
  logic [WIDTH-1:0] data_q;
  logic             step_q;
  logic             done_q;
  logic [WIDTH-1:0] table_q [DEPTH];

  logic [AW-1:0]    adv_idx_d;
  logic             oneshot_end_d;
  logic             tick;
  logic             wr_ok;

`ifdef SEQGEN_PINGPONG_EN
  logic dir_q;
  logic adv_dir_d;
`endif

  function automatic logic [AW-1:0] clamp_idx(input logic [AW-1:0] v);
    logic [AW:0] lim;
    lim = (AW+1)'(DEPTH - 1);
    return ({1'b0, v} > lim) ? lim[AW-1:0] : v;
  endfunction

  seq_tick_divider #(.DIV_W(DIV_W)) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .en_i    (enable && (state_q == S_RUN)),
    .clr_i   (state_q != S_RUN),
    .ratio_i (div_q),
    .tick_o  (tick)
  );

  assign wr_ok = wr_en && (state_q == S_IDLE) && !start;

  always_comb begin
    adv_idx_d     = index_q + 1'b1;
    oneshot_end_d = 1'b0;
`ifdef SEQGEN_PINGPONG_EN
    adv_dir_d     = dir_q;
`endif
    case (mode_q)
      MODE_ONESHOT: begin
        oneshot_end_d = (index_q == last_q);
      end
`ifdef SEQGEN_PINGPONG_EN
      // Each endpoint is emitted once per turn; a one-entry sequence just repeats 0.
      MODE_PINGPONG: begin
        if (dir_q == DIR_UP) begin
          if (index_q == last_q) begin
            if (last_q == '0) begin
              adv_idx_d = '0;
            end else begin
              adv_idx_d = index_q - 1'b1;
              adv_dir_d = DIR_DOWN;
            end
          end
        end else if (index_q == '0) begin
          adv_dir_d = DIR_UP;
        end else begin
          adv_idx_d = index_q - 1'b1;
        end
      end
`endif
      default: begin
        if (index_q == last_q) adv_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ONESHOT;
      div_q   <= '0;
      last_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQGEN_PINGPONG_EN
      dir_q   <= DIR_UP;
`endif
      for (int i = 0; i < DEPTH; i++) table_q[i] <= WIDTH'(i);
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (wr_ok) table_q[wr_addr] <= wr_data;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q <= S_RUN;
            mode_q  <= mode_e'(mode);
            div_q   <= div_ratio;
            last_q  <= clamp_idx(last_idx);
            index_q <= '0;
            data_q  <= table_q[0];
            step_q  <= 1'b1;
`ifdef SEQGEN_PINGPONG_EN
            dir_q   <= DIR_UP;
`endif
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            if (oneshot_end_d) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              index_q <= adv_idx_d;
              data_q  <= table_q[adv_idx_d];
              step_q  <= 1'b1;
`ifdef SEQGEN_PINGPONG_EN
              dir_q   <= adv_dir_d;
`endif
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign index    = index_q;
  assign step     = step_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_param_sequence_generator.sv
// Bench for param_sequence_generator: closed-form playback model checked every cycle,
// plus directed scenarios with literal expectations. Honours SEQGEN_PINGPONG_EN.
module tb_param_sequence_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, start, stop, wr_en;
  logic [1:0]  mode;
  logic [15:0] div_ratio;
  logic [2:0]  last_idx, wr_addr, index;
  logic [7:0]  wr_data, data_out;
  logic        step, busy, done;

  int tests = 0;
  int fails = 0;

  param_sequence_generator #(.WIDTH(8), .DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .div_ratio(div_ratio), .last_idx(last_idx), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_out), .index(index),
    .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef SEQGEN_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  // Playback is a pure function of the number of enabled RUN cycles since start:
  // step k lands after k*(div+1) of them, and its index follows from k alone.
  int         m_state;   // 0 idle, 1 run, 2 finish
  int         m_mode, m_div, m_last, m_cnt, m_k, m_idx;
  logic [7:0] m_data;
  bit         m_step, m_done;
  logic [7:0] m_tab [8];

  function automatic int eff_mode(input int md);
    if (md == 0) return 0;
    if (md == 2 && PP) return 2;
    return 1;
  endfunction

  function automatic int seq_idx(input int md, input int k, input int l);
    int p;
    if (md == 2) begin
      if (l == 0) return 0;
      p = k % (2 * l);
      return (p <= l) ? p : 2 * l - p;
    end
    return k % (l + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_mode = 0; m_div = 0; m_last = 0; m_cnt = 0; m_k = 0;
      m_idx = 0; m_data = 8'h00; m_step = 0; m_done = 0;
      for (int i = 0; i < 8; i++) m_tab[i] = 8'(i);
    end else begin
      m_step = 0;
      m_done = 0;
      case (m_state)
        0: begin
          if (wr_en && !start) m_tab[wr_addr] = wr_data;
          if (start && !stop) begin
            m_state = 1; m_mode = eff_mode(int'(mode)); m_div = int'(div_ratio);
            m_last = int'(last_idx); m_cnt = 0; m_k = 0;
            m_idx = 0; m_data = m_tab[0]; m_step = 1;
          end
        end
        1: begin
          if (stop) begin
            m_state = 0;
          end else if (enable) begin
            m_cnt++;
            if (m_cnt % (m_div + 1) == 0) begin
              m_k = m_cnt / (m_div + 1);
              if (m_mode == 0 && m_k > m_last) begin
                m_state = 2; m_done = 1;
              end else begin
                m_idx = seq_idx(m_mode, m_k, m_last);
                m_data = m_tab[m_idx]; m_step = 1;
              end
            end
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("data_out", int'(data_out), int'(m_data));
    check("index", int'(index), m_idx);
    check("step", int'(step), int'(m_step));
    check("busy", int'(busy), int'(m_state != 0));
    check("done", int'(done), int'(m_done));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input int md, input int dv, input int li);
    mode = 2'(md); div_ratio = 16'(dv); last_idx = 3'(li);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int exp1[6] = '{0, 1, 2, 3, 0, 1};
    int exp3[8];
    int t2_dat[3] = '{8'hA5, 8'h5A, 8'hFF};
    int t5_dat[4] = '{8'hA5, 8'h5A, 8'hFF, 8'h03};
    int st_n[$];
    int st_d[$];
    int done_cnt, done_n, first_step, next_step;
    logic [7:0] held;

    rst_n = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    mode = 2'b00; div_ratio = '0; last_idx = '0; wr_addr = '0; wr_data = '0;
    #1;
    check("rst_data", int'(data_out), 0);
    check("rst_index", int'(index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step_done", int'({step, done}), 0);
    #11 rst_n = 1'b1;
    cyc(1);

    // 1: loop, div 0 -> a new entry every cycle
    enable = 1'b1;
    start_run(1, 0, 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_data", int'(data_out), exp1[i]);
      check("t1_step", int'(step), 1);
    end
    stop_run();
    @(negedge clk);
    check("t1_busy_after_stop", int'(busy), 0);
    cyc(1);

    // 2: one-shot over a rewritten table
    wr_en = 1'b1;
    for (int a = 0; a < 3; a++) begin
      wr_addr = 3'(a); wr_data = 8'(t2_dat[a]);
      cyc(1);
    end
    wr_en = 1'b0;
    start_run(0, 2, 2);
    done_cnt = 0; done_n = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (step) begin st_n.push_back(n); st_d.push_back(int'(data_out)); end
      if (done) begin done_cnt++; done_n = n; end
    end
    check("t2_step_count", st_n.size(), 3);
    for (int i = 0; i < 3 && i < st_n.size(); i++) begin
      check("t2_step_cycle", st_n[i], 3 * i);
      check("t2_step_data", st_d[i], t2_dat[i]);
    end
    check("t2_done_count", done_cnt, 1);
    check("t2_done_cycle", done_n, 9);
    check("t2_busy_end", int'(busy), 0);
    check("t2_data_hold", int'(data_out), 8'hFF);
    cyc(1);

    // 3: mode 10, last 3
    if (PP) exp3 = '{0, 1, 2, 3, 2, 1, 0, 1};
    else    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    start_run(2, 0, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_index", int'(index), exp3[i]);
    end
    stop_run();

    // 4: pause 5 cycles mid-period with div 3
    start_run(1, 3, 7);
    first_step = -1; next_step = -1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (step) begin
        if (first_step < 0) first_step = n;
        else if (next_step < 0) next_step = n;
      end
      if (n == 1) enable = 1'b0;
      if (n == 6) enable = 1'b1;
    end
    check("t4_first_step", first_step, 0);
    check("t4_step_spacing", next_step - first_step, 9);
    stop_run();

    // 5: dropped write in RUN, then stop+start together
    start_run(1, 0, 3);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
    cyc(2);
    wr_en = 1'b0;
    @(negedge clk);
    held = data_out;
    stop = 1'b1; start = 1'b1;
    cyc(1);
    stop = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t5_data_held", int'(data_out), int'(held));
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_step", int'(step), 0);
    cyc(1);
    start_run(0, 0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_readback", int'(data_out), t5_dat[i]);
    end
    @(negedge clk);
    check("t5_done_pulse", int'(done), 1);
    cyc(2);

    // 6: async reset mid-run
    start_run(1, 1, 7);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_data", int'(data_out), 0);
    check("t6_index", int'(index), 0);
    check("t6_busy_step_done", int'({busy, step, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    start_run(1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_restart", int'(data_out), i);
    end
    cyc(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
